// File: rtl/aes_key_rounds.sv
// AES-128 key expansion: derives RoundKey_1..10 from Key, registered.
// Ports: clk, rst (async active-low), Key[127:0], RoundKey_1..10[127:0].
module aes_key_rounds (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] Key,
    output logic [127:0] RoundKey_1,
    output logic [127:0] RoundKey_2,
    output logic [127:0] RoundKey_3,
    output logic [127:0] RoundKey_4,
    output logic [127:0] RoundKey_5,
    output logic [127:0] RoundKey_6,
    output logic [127:0] RoundKey_7,
    output logic [127:0] RoundKey_8,
    output logic [127:0] RoundKey_9,
    output logic [127:0] RoundKey_10
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index 1 is the least significant byte so RCON[r] is Rcon[r].
    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]],
                SBOX[x[15:8]],  SBOX[x[7:0]]};
    endfunction

    logic [127:0] w_rk [1:10];
    logic [127:0] r_rk [1:10];

    // Full ten-round chain in one combinational cone.
    always_comb begin
        logic [127:0] v_prev;
        logic [31:0]  v_t;
        logic [31:0]  v_w0, v_w1, v_w2, v_w3;
        v_prev = Key;
        for (logic [3:0] r = 4'd1; r <= 4'd10; r++) begin
            // RotWord then SubWord on the last word of the previous round.
            v_t  = sub_word({v_prev[23:0], v_prev[31:24]})
                 ^ {RCON[r], 24'h0};
            v_w0 = v_prev[127:96] ^ v_t;
            v_w1 = v_prev[95:64]  ^ v_w0;
            v_w2 = v_prev[63:32]  ^ v_w1;
            v_w3 = v_prev[31:0]   ^ v_w2;
            w_rk[r] = {v_w0, v_w1, v_w2, v_w3};
            v_prev  = w_rk[r];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r <= 10; r++) r_rk[r] <= '0;
        end else begin
            for (int r = 1; r <= 10; r++) r_rk[r] <= w_rk[r];
        end
    end

    assign RoundKey_1  = r_rk[1];
    assign RoundKey_2  = r_rk[2];
    assign RoundKey_3  = r_rk[3];
    assign RoundKey_4  = r_rk[4];
    assign RoundKey_5  = r_rk[5];
    assign RoundKey_6  = r_rk[6];
    assign RoundKey_7  = r_rk[7];
    assign RoundKey_8  = r_rk[8];
    assign RoundKey_9  = r_rk[9];
    assign RoundKey_10 = r_rk[10];

endmodule

// File: tb/tb_aes_key_rounds.sv
// Bench for aes_key_rounds: known FIPS-197 keys, reset, latency, random.
// Reference S-box is derived from GF(2^8) inversion plus affine map.
module tb_aes_key_rounds;

    logic         clk;
    logic         rst;
    logic [127:0] Key;
    logic [127:0] rk1, rk2, rk3, rk4, rk5, rk6, rk7, rk8, rk9, rk10;
    logic [127:0] rk [1:10];

    int vec = 0;
    int err = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_rk [1:10];

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;

    aes_key_rounds dut (
        .clk(clk), .rst(rst), .Key(Key),
        .RoundKey_1(rk1), .RoundKey_2(rk2), .RoundKey_3(rk3),
        .RoundKey_4(rk4), .RoundKey_5(rk5), .RoundKey_6(rk6),
        .RoundKey_7(rk7), .RoundKey_8(rk8), .RoundKey_9(rk9),
        .RoundKey_10(rk10)
    );

    assign rk[1] = rk1;  assign rk[2] = rk2;  assign rk[3] = rk3;
    assign rk[4] = rk4;  assign rk[5] = rk5;  assign rk[6] = rk6;
    assign rk[7] = rk7;  assign rk[8] = rk8;  assign rk[9] = rk9;
    assign rk[10] = rk10;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                  ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 1; r <= 10; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic test_reset();
        rst = 1'b0;
        Key = KEY_A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int r = 1; r <= 10; r++) begin
            vec++;
            if (rk[r] !== 128'h0) begin
                err++;
                $display("FAIL reset_hold rk%0d got %h want 0", r, rk[r]);
            end
        end
        rst = 1'b1;
        model(KEY_A);
        @(posedge clk); #1;
        for (int r = 1; r <= 10; r++) begin
            vec++;
            if (rk[r] !== exp_rk[r]) begin
                err++;
                $display("FAIL reset_release rk%0d got %h want %h",
                         r, rk[r], exp_rk[r]);
            end
        end
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        for (int r = 1; r <= 10; r++) begin
            vec++;
            if (rk[r] !== 128'h0) begin
                err++;
                $display("FAIL reset_async rk%0d got %h want 0", r, rk[r]);
            end
        end
        Key = KEY_C;
        @(posedge clk); #1;
        vec++;
        if (rk1 !== 128'h0 || rk10 !== 128'h0) begin
            err++;
            $display("FAIL reset_keychg rk1 %h rk10 %h want 0", rk1, rk10);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_known(input logic [127:0] k,
                              input logic [127:0] e1,
                              input logic [127:0] e2,
                              input logic [127:0] e10,
                              input string nm);
        @(negedge clk);
        Key = k;
        model(k);
        @(posedge clk); #1;
        vec++;
        if (rk1 !== e1) begin
            err++;
            $display("FAIL %s_rk1 got %h want %h", nm, rk1, e1);
        end
        vec++;
        if (rk2 !== e2) begin
            err++;
            $display("FAIL %s_rk2 got %h want %h", nm, rk2, e2);
        end
        vec++;
        if (rk10 !== e10) begin
            err++;
            $display("FAIL %s_rk10 got %h want %h", nm, rk10, e10);
        end
        for (int r = 1; r <= 10; r++) begin
            vec++;
            if (rk[r] !== exp_rk[r]) begin
                err++;
                $display("FAIL %s_model rk%0d got %h want %h",
                         nm, r, rk[r], exp_rk[r]);
            end
        end
    endtask

    task automatic test_key_switch();
        logic [127:0] zk [1:10];
        @(negedge clk);
        Key = 128'h0;
        model(128'h0);
        zk = exp_rk;
        @(posedge clk);
        @(negedge clk);
        Key = KEY_A;
        model(KEY_A);
        #1;
        for (int r = 1; r <= 10; r++) begin
            vec++;
            if (rk[r] !== zk[r]) begin
                err++;
                $display("FAIL switch_hold rk%0d got %h want %h",
                         r, rk[r], zk[r]);
            end
        end
        @(posedge clk); #1;
        for (int r = 1; r <= 10; r++) begin
            vec++;
            if (rk[r] !== exp_rk[r]) begin
                err++;
                $display("FAIL switch_new rk%0d got %h want %h",
                         r, rk[r], exp_rk[r]);
            end
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int r = 1; r <= 10; r++) begin
            vec++;
            if (rk[r] !== 128'h0) begin
                err++;
                $display("FAIL midrst_clear rk%0d got %h want 0", r, rk[r]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if (rk1 !== 128'h0) begin
            err++;
            $display("FAIL midrst_wait rk1 got %h want 0", rk1);
        end
        @(posedge clk); #1;
        for (int r = 1; r <= 10; r++) begin
            vec++;
            if (rk[r] !== exp_rk[r]) begin
                err++;
                $display("FAIL midrst_restore rk%0d got %h want %h",
                         r, rk[r], exp_rk[r]);
            end
        end
    endtask

    task automatic test_hold();
        repeat (2) begin
            @(posedge clk); #1;
            for (int r = 1; r <= 10; r++) begin
                vec++;
                if (rk[r] !== exp_rk[r]) begin
                    err++;
                    $display("FAIL hold rk%0d got %h want %h",
                             r, rk[r], exp_rk[r]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] k;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            k = {$urandom, $urandom, $urandom, $urandom};
            Key = k;
            model(k);
            @(posedge clk); #1;
            for (int r = 1; r <= 10; r++) begin
                vec++;
                if (rk[r] !== exp_rk[r]) begin
                    err++;
                    $display("FAIL random key %h rk%0d got %h want %h",
                             k, r, rk[r], exp_rk[r]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        Key = KEY_A;
        build_sbox();
        test_reset();
        test_known(KEY_A,
                   128'ha0fafe1788542cb123a339392a6c7605,
                   128'hf2c295f27a96b9435935807a7359f67f,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fipsA");
        test_known(128'h0,
                   128'h62636363626363636263636362636363,
                   128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
                   128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero");
        test_known(KEY_C,
                   128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                   128'hb692cf0b643dbdf1be9bc5006830b3fe,
                   128'h13111d7fe3944a17f307a78b4d2b30c5, "fipsC1");
        test_key_switch();
        test_mid_reset();
        test_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
